// File: rtl/tristate_bus_pkg.sv
// Shared types and helpers for the tristate bus arbiter: FSM state encoding
// and the round-robin search used to pick the next bus owner.
`timescale 1ns/1ps
package tristate_bus_pkg;

  localparam int unsigned MAX_N   = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_TURN
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned grant_w(input int unsigned n);
    return $clog2(n);
  endfunction

  // Searches ptr, ptr+1, ... wrapping at n (not at a power of two).
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] req,
                                       input logic [IDX_W-1:0] ptr,
                                       input int unsigned      n);
    rr_pick_t    r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        c = 32'(ptr) + k;
        if (c >= n) c = c - n;
        if (!r.found && req[c[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_picker.sv
// Combinational round-robin priority picker shared by the IDLE and TURN
// arbitration paths.
`timescale 1ns/1ps
module rr_priority_picker
  import tristate_bus_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          found,
  output logic [GW-1:0] idx
);

  logic [MAX_N-1:0] req_ext;
  logic [IDX_W-1:0] ptr_ext;
  rr_pick_t         pick;

  assign req_ext = MAX_N'(req);
  assign ptr_ext = IDX_W'(ptr);
  assign pick    = rr_pick(req_ext, ptr_ext, N);
  assign found   = pick.found;
  assign idx     = GW'(pick.idx);

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus: one-hot-or-zero
// driver enables, bounded ownership and an all-released gap between owners.
`timescale 1ns/1ps
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1,
  localparam int unsigned GW         = grant_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  sel,
  output logic [GW-1:0] grant_id,
  output logic          bus_busy,
  output logic          turnaround
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_MAX = TW'(TURN_CYCLES);
  localparam logic [GW-1:0] LAST_IDX = GW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  sel_q, sel_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          turn_q, turn_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          release_own;

  rr_priority_picker #(.N(N), .GW(GW)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_own = !req[grant_q] ||
                       ((hold_q == HOLD_MAX) && ((req & ~sel_q) != '0));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    turn_d  = turn_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d         = ST_OWN;
          sel_d           = '0;
          sel_d[pick_idx] = 1'b1;
          grant_d         = pick_idx;
          busy_d          = 1'b1;
          hold_d          = HW'(1);
        end
      end
      ST_OWN: begin
        if (release_own) begin
          state_d = ST_TURN;
          sel_d   = '0;
          busy_d  = 1'b0;
          turn_d  = 1'b1;
          ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          tcnt_d  = TW'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_TURN: begin
        // Arbitration in the last gap cycle lets the new owner's enable
        // rise on the very edge that ends the gap.
        if (tcnt_q == TURN_MAX) begin
          turn_d = 1'b0;
          tcnt_d = '0;
          if (pick_found) begin
            state_d         = ST_OWN;
            sel_d           = '0;
            sel_d[pick_idx] = 1'b1;
            grant_d         = pick_idx;
            busy_d          = 1'b1;
            hold_d          = HW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
        turn_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      turn_q  <= turn_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign sel        = sel_q;
  assign grant_id   = grant_q;
  assign bus_busy   = busy_q;
  assign turnaround = turn_q;

  a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(sel_q));
  a_grant_match: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q |-> sel_q[grant_q]);
  a_owner_gap: assert property (@(posedge clk) disable iff (!rst_n)
    ((sel_q != '0) && ($past(sel_q) != '0)) |-> (sel_q == $past(sel_q)));

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed checks of the tristate bus arbiter with N=4, MAX_HOLD=4, TURN_CYCLES=1.
`timescale 1ns/1ps
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] sel;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       turnaround;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(4), .TURN_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .sel        (sel),
    .grant_id   (grant_id),
    .bus_busy   (bus_busy),
    .turnaround (turnaround)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [21] = '{
    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
    4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
    4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
    4'b0001
  };

  logic [3:0] prev_sel;

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sel", 32'(sel), 32'h0);
    check_val("rst_busy", 32'(bus_busy), 32'h0);
    check_val("rst_gid", 32'(grant_id), 32'h0);
    check_val("rst_turn", 32'(turnaround), 32'h0);

    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    tick();
    check_val("idle_sel", 32'(sel), 32'h0);

    // round robin from ptr=0
    req = 4'b1111;
    for (int i = 0; i < 21; i++) begin
      tick();
      check_val($sformatf("rr_sel%0d", i), 32'(sel), 32'(rr_exp[i]));
      check_val($sformatf("rr_turn%0d", i), 32'(turnaround),
                32'(rr_exp[i] == 4'b0000));
    end
    check_val("rr_gid", 32'(grant_id), 32'h0);
    req = 4'b0000;
    tick();
    tick();

    // single request: ptr=1 now
    req = 4'b0100;
    tick();
    check_val("single_sel", 32'(sel), 32'h4);
    check_val("single_gid", 32'(grant_id), 32'h2);
    check_val("single_busy", 32'(bus_busy), 32'h1);
    req = 4'b0000;
    tick();
    check_val("drop_sel", 32'(sel), 32'h0);
    check_val("drop_turn", 32'(turnaround), 32'h1);
    check_val("drop_busy", 32'(bus_busy), 32'h0);
    tick();
    check_val("idle2_turn", 32'(turnaround), 32'h0);
    check_val("idle2_sel", 32'(sel), 32'h0);

    // hold saturation: ptr=3, sole requester 1
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val($sformatf("sat_sel%0d", i), 32'(sel), 32'h2);
    end
    req = 4'b1010;
    tick();
    check_val("preempt_sel", 32'(sel), 32'h0);
    check_val("preempt_turn", 32'(turnaround), 32'h1);
    tick();
    check_val("preempt_next", 32'(sel), 32'h8);
    check_val("preempt_gid", 32'(grant_id), 32'h3);

    // wrap and skip
    req = 4'b0101;
    tick();
    check_val("wrap_gap", 32'(sel), 32'h0);
    tick();
    check_val("wrap_sel", 32'(sel), 32'h1);
    check_val("wrap_gid", 32'(grant_id), 32'h0);
    req = 4'b0100;
    tick();
    check_val("skip_gap", 32'(sel), 32'h0);
    tick();
    check_val("skip_sel", 32'(sel), 32'h4);
    check_val("skip_gid", 32'(grant_id), 32'h2);
    req = 4'b0000;
    tick();
    tick();

    // asynchronous reset mid-grant (ptr=3 -> picks 0)
    req = 4'b0001;
    tick();
    check_val("pre_rst_sel", 32'(sel), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_sel", 32'(sel), 32'h0);
    check_val("async_rst_busy", 32'(bus_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // random contention
    prev_sel = 4'b0000;
    for (int i = 0; i < 10000; i++) begin
      req = 4'($urandom_range(0, 15));
      tick();
      check_val("rand_onehot", 32'($countones(sel) <= 1), 32'h1);
      if (sel != 4'b0000 && prev_sel != 4'b0000)
        check_val("rand_gap", 32'(sel), 32'(prev_sel));
      if (bus_busy)
        check_val("rand_gid", 32'(sel), 32'(4'b0001 << grant_id));
      prev_sel = sel;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
